// File: rtl/mining_pkg.sv
// Shared mining-datapath definitions: adder phase codes, result width default,
// the adder done-flag timeout and the message sequencer FSM states.
package mining_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_IDLE = 2'b00;
  localparam phase_t PH_LOAD = 2'b01;
  localparam phase_t PH_SUM  = 2'b10;
  localparam phase_t PH_OUT  = 2'b11;

  localparam int DEFAULT_SUM_W = 13;
  localparam int FINE_TIMEOUT  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_REPORT,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/msg_buffer.sv
// Message byte store: DEPTH x 8 register file, synchronous write, asynchronous read.
module msg_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
  input  logic [7:0]                 wr_data_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
  output logic [7:0]                 rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/msg_sequencer.sv
// Buffers a message byte stream, replays it into the bit-sum adder one byte per
// cycle, waits for the adder done flag and returns the bit count with the length.
module msg_sequencer
  import mining_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SUM_W = DEFAULT_SUM_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  output logic [7:0]               add_in,
  output logic [1:0]               add_state,
  output logic                     add_clr,
  input  logic                     add_fine,
  input  logic [SUM_W-1:0]         add_sum,
  output logic                     res_valid,
  output logic [SUM_W-1:0]         res_sum,
  output logic [$clog2(DEPTH):0]   res_len,
  output logic                     res_err,
  input  logic                     res_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(FINE_TIMEOUT);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("msg_sequencer: DEPTH must be a power of two and at least 2");
  end
  if (8 * DEPTH >= (1 << SUM_W)) begin : g_bad_sum_w
    $error("msg_sequencer: SUM_W too narrow for 8*DEPTH");
  end

  seq_state_t     state_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [LW-1:0]  len_q;
  logic [TW-1:0]  tmo_q;
  logic           wr_ready_q;
  logic [7:0]     add_in_q;
  phase_t         add_state_q;
  logic           add_clr_q;
  logic           res_valid_q;
  logic [SUM_W-1:0] res_sum_q;
  logic [LW-1:0]  res_len_q;
  logic           res_err_q;

  logic           wr_fire;
  logic           wr_end;
  logic           feed_last;
  logic [AW-1:0]  rd_addr;
  logic [7:0]     rd_data;

  assign wr_fire   = wr_valid && wr_ready_q;
  assign wr_end    = wr_last || (wr_ptr_q == AW'(DEPTH - 1));
  assign feed_last = ({1'b0, rd_ptr_q} == (len_q - LW'(1)));
  // Outputs are registered, so the buffer is read one byte ahead of what add_in shows.
  assign rd_addr   = (state_q == S_CLEAR) ? '0 : rd_ptr_q + AW'(1);

  msg_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk       (clk),
    .wr_en_i   (wr_fire),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      wr_ready_q  <= 1'b0;
      add_in_q    <= '0;
      add_state_q <= PH_IDLE;
      add_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_len_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      add_clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wr_ready_q <= 1'b1;
          if (wr_fire) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (wr_end) begin
              len_q      <= {1'b0, wr_ptr_q} + LW'(1);
              wr_ready_q <= 1'b0;
              add_clr_q  <= 1'b1;
              state_q    <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          rd_ptr_q    <= '0;
          add_in_q    <= rd_data;
          add_state_q <= PH_SUM;
          state_q     <= S_FEED;
        end
        S_FEED: begin
          if (feed_last) begin
            add_in_q    <= '0;
            add_state_q <= PH_OUT;
            tmo_q       <= '0;
            state_q     <= S_REPORT;
          end else begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            add_in_q <= rd_data;
          end
        end
        S_REPORT: begin
          if (add_fine || tmo_q == TW'(FINE_TIMEOUT - 1)) begin
            res_sum_q   <= add_fine ? add_sum : '0;
            res_err_q   <= !add_fine;
            res_len_q   <= len_q;
            res_valid_q <= 1'b1;
            add_state_q <= PH_IDLE;
            state_q     <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            wr_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_ready  = wr_ready_q;
  assign add_in    = add_in_q;
  assign add_state = add_state_q;
  assign add_clr   = add_clr_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_len   = res_len_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// Self-checking bench for msg_sequencer: table of messages plus hand-written
// stall, timeout and mid-feed reset sequences, against a simple adder stub.
module tb_msg_sequencer;
  import mining_pkg::*;

  localparam int DEPTH = 16;
  localparam int SUM_W = 13;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wrValid = 1'b0;
  logic [7:0]       wrData = '0;
  logic             wrLast = 1'b0;
  logic             wrReady;
  logic [7:0]       addIn;
  logic [1:0]       addState;
  logic             addClr;
  logic             addFine;
  logic [SUM_W-1:0] addSum;
  logic             resValid;
  logic [SUM_W-1:0] resSum;
  logic [LW-1:0]    resLen;
  logic             resErr;
  logic             resReady = 1'b1;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int acceptCyc = 0;
  bit fineEnable = 1'b1;

  typedef struct {
    int               n;
    logic [15:0][7:0] data;
    bit               useLast;
    int               expSum;
    int               expLen;
    bit               expErr;
  } vec_t;

  typedef struct {
    logic [SUM_W-1:0] sum;
    logic [LW-1:0]    len;
    logic             err;
  } res_t;

  logic [7:0] feedQ[$];
  res_t       resQ[$];

  msg_sequencer #(
    .DEPTH (DEPTH),
    .SUM_W (SUM_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wrValid),
    .wr_data   (wrData),
    .wr_last   (wrLast),
    .wr_ready  (wrReady),
    .add_in    (addIn),
    .add_state (addState),
    .add_clr   (addClr),
    .add_fine  (addFine),
    .add_sum   (addSum),
    .res_valid (resValid),
    .res_sum   (resSum),
    .res_len   (resLen),
    .res_err   (resErr),
    .res_ready (resReady)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Adder stub: clears on add_clr, sums set bits while accumulating, raises
  // its done flag the cycle after it first sees the report phase.
  logic [SUM_W-1:0] adderAcc = '0;
  logic             adderDone = 1'b0;
  always @(posedge clk) begin
    if (addClr) begin
      adderAcc  <= '0;
      adderDone <= 1'b0;
    end else begin
      if (addState == PH_SUM) adderAcc <= adderAcc + SUM_W'($countones(addIn));
      adderDone <= fineEnable && (addState == PH_OUT);
    end
  end
  assign addFine = adderDone;
  assign addSum  = adderAcc;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every feed-phase byte must match the next byte written, in order.
  always @(posedge clk) begin
    #1;
    if (addState == PH_SUM) begin
      if (feedQ.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL feed byte: got %0h, expected no feed", addIn);
      end else begin
        checkOutput("feed byte", {24'd0, addIn}, {24'd0, feedQ.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input int n, input logic [127:0] d, input bit last,
                                 input int s, input int l, input bit e);
    vec_t v;
    v.n = n; v.data = d; v.useLast = last; v.expSum = s; v.expLen = l; v.expErr = e;
    return v;
  endfunction

  task automatic sendByte(input logic [7:0] d, input bit last);
    int waits = 0;
    wrValid = 1'b1;
    wrData  = d;
    wrLast  = last;
    while (!wrReady && waits < 50) begin
      tick();
      waits++;
    end
    checkOutput("write accepted", {31'd0, wrReady}, 32'd1);
    feedQ.push_back(d);
    acceptCyc = cyc;
    tick();
    wrValid = 1'b0;
    wrLast  = 1'b0;
  endtask

  // Drives a whole message and queues its expected result; returns in the CLEAR cycle.
  task automatic applyStimulus(input vec_t v);
    res_t r;
    for (int i = 0; i < v.n; i++) sendByte(v.data[i], v.useLast && (i == v.n - 1));
    r.sum = SUM_W'(v.expSum);
    r.len = LW'(v.expLen);
    r.err = v.expErr;
    resQ.push_back(r);
  endtask

  task automatic waitResult(input string name, input int expLat);
    res_t r;
    int waits = 0;
    while (!resValid && waits < 60) begin
      tick();
      waits++;
    end
    checkOutput({name, " res_valid"}, {31'd0, resValid}, 32'd1);
    if (resValid) begin
      checkOutput({name, " latency"}, cyc - acceptCyc, expLat);
      if (resQ.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL %s scoreboard: got result, expected none", name);
      end else begin
        r = resQ.pop_front();
        checkOutput({name, " res_sum"}, {19'd0, resSum}, {19'd0, r.sum});
        checkOutput({name, " res_len"}, {27'd0, resLen}, {27'd0, r.len});
        checkOutput({name, " res_err"}, {31'd0, resErr}, {31'd0, r.err});
      end
    end
  endtask

  task automatic runVector(input vec_t v, input string name, input int expLat);
    applyStimulus(v);
    checkOutput({name, " clr pulse"}, {29'd0, addClr, addState, wrReady}, {29'd0, 1'b1, PH_IDLE, 1'b0});
    tick();
    checkOutput({name, " feed start"}, {29'd0, addClr, addState, wrReady}, {29'd0, 1'b0, PH_SUM, 1'b0});
    waitResult(name, expLat);
  endtask

  task automatic checkReleased(input string name);
    checkOutput({name, " after handshake"}, {30'd0, resValid, wrReady}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = mkVec(1,  128'hFF,           1, 8,   1,  0);
    vecs[1] = mkVec(4,  128'hF0070301,     1, 10,  4,  0);
    vecs[2] = mkVec(16, {16{8'hFF}},       0, 128, 16, 0);
    vecs[3] = mkVec(1,  128'h00,           1, 0,   1,  0);
    vecs[4] = mkVec(3,  128'h813CA5,       1, 10,  3,  0);
    vecs[5] = mkVec(2,  128'h7F80,         1, 8,   2,  0);
    vecs[6] = mkVec(16, {16{8'h01}},       1, 16,  16, 0);
    vecs[7] = mkVec(15, {16{8'h03}},       1, 30,  15, 0);

    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset wr_ready",  {31'd0, wrReady},  32'd0);
    checkOutput("reset add_in",    {24'd0, addIn},    32'd0);
    checkOutput("reset add_state", {30'd0, addState}, 32'd0);
    checkOutput("reset add_clr",   {31'd0, addClr},   32'd0);
    checkOutput("reset res_valid", {31'd0, resValid}, 32'd0);
    checkOutput("reset res_sum",   {19'd0, resSum},   32'd0);
    checkOutput("reset res_len",   {27'd0, resLen},   32'd0);
    checkOutput("reset res_err",   {31'd0, resErr},   32'd0);
    reset = 1'b0;
    tick();
    checkOutput("wr_ready after release", {31'd0, wrReady}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i), vecs[i].n + 4);
      tick();
      checkReleased($sformatf("vec%0d", i));
    end

    // Adder never reports: eight report cycles then an error result.
    fineEnable = 1'b0;
    runVector(mkVec(2, 128'h010F, 1, 0, 2, 1), "timeout", 2 + 10);
    tick();
    checkReleased("timeout");
    fineEnable = 1'b1;

    // Stalled consumer, then a second message straight after the handshake.
    resReady = 1'b0;
    runVector(mkVec(1, 128'h33, 1, 4, 1, 0), "stallA", 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall hold", {12'd0, resValid, resErr, resLen, resSum},
                  {12'd0, 1'b1, 1'b0, 5'd1, 13'd4});
      checkOutput("stall wr_ready", {31'd0, wrReady}, 32'd0);
    end
    resReady = 1'b1;
    tick();
    checkReleased("stallA");
    runVector(mkVec(1, 128'h01, 1, 1, 1, 0), "b2bB", 5);
    checkOutput("b2b accept cycle", cyc - acceptCyc, 5);
    tick();
    checkReleased("b2bB");

    // Reset in the middle of the feed phase aborts the message.
    applyStimulus(mkVec(4, {4{8'hFF}}, 1, 32, 4, 0));
    tick();
    tick();
    checkOutput("pre-reset feeding", {30'd0, addState}, {30'd0, PH_SUM});
    reset = 1'b1;
    tick();
    checkOutput("midreset outputs", {19'd0, addState, addClr, resValid, wrReady, addIn},
                32'd0);
    feedQ.delete();
    resQ.delete();
    reset = 1'b0;
    tick();
    checkOutput("midreset wr_ready", {31'd0, wrReady}, 32'd1);
    runVector(mkVec(1, 128'h07, 1, 3, 1, 0), "recover", 5);
    tick();
    checkReleased("recover");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/msg_sequencer.md
# msg_sequencer

Feeds buffered message bytes to the bit-sum adder stage in the mining datapath and collects its result. It accepts a message as a byte stream over a valid/ready write port and stores it locally. It then clears the adder, drives the 2-bit phase code and one byte per cycle, waits for the adder's `fine` flag, and presents the 13-bit bit-count with the message length on a valid/ready result port.

## Interface
- `DEPTH`, 16: maximum message length in bytes; power of two, ≥2.
- `SUM_W`, 13: width of the adder result.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  message byte valid.
- `wr_data`  in  8  message byte.
- `wr_last`  in  1  final byte of message (qualified by `wr_valid`).
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `add_in`  out  8  byte presented to adder.
- `add_state`  out  2  phase code to adder: 00 idle, 01 load, 10 accumulate, 11 report.
- `add_clr`  out  1  one-cycle clear pulse to adder reset input.
- `add_fine`  in  1  adder done flag.
- `add_sum`  in  SUM_W  adder result.
- `res_valid`  out  1  result valid; held until accepted.
- `res_sum`  out  SUM_W  captured bit count.
- `res_len`  out  $clog2(DEPTH)+1  message length in bytes.
- `res_err`  out  1  adder timeout; `res_sum` forced to 0.
- `res_ready`  in  1  result consumer ready.

## Operation
- FSM states: IDLE, CLEAR, FEED, REPORT, DONE.
- IDLE:
  - `wr_ready`=1. Each accepted byte is written at `wr_ptr`, and `wr_ptr` increments.
  - Leave to CLEAR on an accepted byte with `wr_last`=1, or on an accepted byte when `wr_ptr`==DEPTH-1. The second case forces end of message.
  - `len` = `wr_ptr`+1, latched.
- CLEAR: one cycle, `add_clr`=1, `add_state`=00. Reset `rd_ptr` to 0, then go to FEED.
- FEED:
  - `add_state`=10, `add_in`=`buf[rd_ptr]`, `rd_ptr` increments each cycle.
  - After `len` cycles, go to REPORT.
- REPORT:
  - `add_state`=11, and the timeout counter increments.
  - On the first cycle with `add_fine`=1: capture `add_sum` into `res_sum`, `res_err`=0, go to DONE.
  - If 8 REPORT cycles pass without `add_fine`: `res_sum`=0, `res_err`=1, go to DONE.
- DONE:
  - `res_valid`=1, `add_state`=00, `wr_ready`=0.
  - On `res_valid && res_ready`: clear `wr_ptr`, go to IDLE.
- `add_state`=00 and `add_in`=0 in IDLE, CLEAR and DONE. Code 01 is reserved and never driven.
- Width rule: the maximum sum is 8×DEPTH and must fit in SUM_W. Elaboration fails if 8×DEPTH ≥ 2^SUM_W.
- Message length is always ≥1, because `wr_last` travels with a data byte.

## Timing
- Reset values:
  - `wr_ready`=0 in the reset cycle, 1 in the first cycle after.
  - `add_in`=0, `add_state`=00, `add_clr`=0.
  - `res_valid`=0, `res_sum`=0, `res_len`=0, `res_err`=0.
  - FSM in IDLE, pointers 0.
- For an N-byte message whose last byte is accepted in cycle 0:
  - cycle 1: CLEAR.
  - cycles 2..N+1: FEED, byte k in cycle 2+k.
  - cycle N+2: first REPORT cycle.
  - cycle N+3: `add_fine` seen and sum captured.
  - cycle N+4: `res_valid`=1.
- Result latency is N+4 cycles with a conforming adder.
- Back-to-back: the handshake in cycle D gives IDLE with `wr_ready`=1 in D+1.
- Writes are never accepted outside IDLE. No new message overlaps an outstanding result.
- Reset mid-operation aborts the message. The buffer contents are don't-care, and all outputs return to reset values next cycle.
- `res_*` stay stable while `res_valid && !res_ready`.

## Structure
- Shared package `mining_pkg`:
  - phase constants `PH_IDLE`=2'b00, `PH_LOAD`=2'b01, `PH_SUM`=2'b10, `PH_OUT`=2'b11, also used by the adder.
  - `SUM_W` default.
  - timeout constant `FINE_TIMEOUT`=8.
- Sub-module `msg_buffer`: DEPTH×8 register file with a synchronous write port and an asynchronous read port. FSM, pointers and counters stay in `msg_sequencer`.

## Test plan
- Single byte 0xFF with `wr_last` → CLEAR pulse, one FEED cycle with `add_in`=0xFF. `res_sum`=8, `res_len`=1, `res_valid` 5 cycles after acceptance.
- Bytes 0x01,0x03,0x07,0xF0 (last) → `add_in` sequence matches in order. `res_sum`=10, `res_len`=4.
- 16 bytes of 0xFF without `wr_last` → forced end after the 16th byte. `res_sum`=128, `res_len`=16, `wr_ready`=0 from the next cycle.
- `add_fine` held low by the bench → after 8 REPORT cycles `res_err`=1, `res_sum`=0.
- `res_ready` held low for 5 cycles, then two messages back-to-back → result stable while stalled. Second message accepted the cycle after the handshake, and its sum is not contaminated by the first.
- `reset` asserted in the middle of FEED → next cycle `add_state`=00, `res_valid`=0, `wr_ready`=1 one cycle after release.
